// File: rtl/mat_pkg.sv
// Shared definitions for the matrix coprocessor sequencer: opcodes, FSM states
// and the default maximum matrix dimension.
package mat_pkg;

    localparam int MAX_N = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_SMUL = 3'b011;
    localparam logic [2:0] OP_DET  = 3'b100;
    localparam logic [2:0] OP_TRN  = 3'b101;
    localparam logic [2:0] OP_NEG  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } st_t;

    // Commands that are rejected without touching memory.
    function automatic logic bad_cmd(logic [2:0] op, logic [2:0] n, int max_n);
        return (op == OP_DET) || (n < 3'd2) || (int'(n) > max_n);
    endfunction

endpackage

// File: rtl/mat_index_gen.sv
// Row/column/inner index counters bounded by the latched dimension; 3-D mode
// walks k fastest (matrix multiply), 2-D mode keeps k at 0.
module mat_index_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    input  logic       mode3d,
    input  logic [2:0] n,
    output logic [2:0] i,
    output logic [2:0] j,
    output logic [2:0] k,
    output logic       last
);

    logic [2:0] nm1;
    logic       k_wrap;
    logic       j_wrap;
    logic       i_wrap;

    assign nm1    = n - 3'd1;
    assign k_wrap = !mode3d || (k == nm1);
    assign j_wrap = (j == nm1);
    assign i_wrap = (i == nm1);
    assign last   = k_wrap && j_wrap && i_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (adv) begin
            if (!k_wrap) begin
                k <= k + 3'd1;
            end else begin
                k <= '0;
                if (!j_wrap) begin
                    j <= j + 3'd1;
                end else begin
                    j <= '0;
                    i <= i_wrap ? 3'd0 : i + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mat_op_sequencer.sv
// Matrix op sequencer: fetches operand pairs, drives the element ALU and writes
// results. MAT_SEQ_SAT_EN selects saturating (vs wrapping) multiply accumulation.
module mat_op_sequencer #(
    parameter int MAX_N = mat_pkg::MAX_N,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [2:0]           size,
    input  logic signed [7:0]    scalar,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AW-1:0]        a_addr,
    output logic [AW-1:0]        b_addr,
    input  logic signed [7:0]    a_rdata,
    input  logic signed [7:0]    b_rdata,
    output logic [AW-1:0]        r_addr,
    output logic signed [7:0]    r_wdata,
    output logic                 r_we,
    output logic [2:0]           alu_op,
    output logic signed [7:0]    alu_a,
    output logic signed [7:0]    alu_b,
    output logic [2:0]           alu_s,
    input  logic signed [7:0]    alu_res
);
    import mat_pkg::*;

    st_t               state;
    logic [2:0]        op_q;
    logic [2:0]        n_q;
    logic signed [7:0] sc_q;
    logic signed [7:0] acc;
    logic signed [7:0] acc_nx;
    logic signed [8:0] sum9;
    logic [2:0]        i, j, k;
    logic              last;
    logic              is_mul;
    logic              k_last;

    function automatic logic [AW-1:0] lin(logic [2:0] r, logic [2:0] c);
        return AW'(int'(r) * MAX_N + int'(c));
    endfunction

    assign is_mul = (op_q == OP_MULT);
    assign k_last = (k == n_q - 3'd1);

    mat_index_gen u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_IDLE && start),
        .adv   (state == S_EXEC),
        .mode3d(is_mul),
        .n     (n_q),
        .i     (i),
        .j     (j),
        .k     (k),
        .last  (last)
    );

    // Addresses follow the live indices, which hold steady across FETCH and EXEC.
    assign a_addr = lin(i, is_mul ? k : j);
    assign b_addr = is_mul ? lin(k, j) : lin(i, j);

    assign sum9 = {acc[7], acc} + {alu_res[7], alu_res};

`ifdef MAT_SEQ_SAT_EN
    always_comb begin
        acc_nx = sum9[7:0];
        if (sum9[8] != sum9[7])
            acc_nx = sum9[8] ? -8'sd128 : 8'sd127;
    end
`else
    assign acc_nx = sum9[7:0];
`endif

    // Operand pairs are only meaningful while read data is valid (EXEC).
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        r_wdata = '0;
        if (state == S_EXEC) begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    alu_a   = a_rdata;
                    alu_b   = b_rdata;
                    r_wdata = alu_res;
                end
                OP_MULT: begin
                    alu_a   = a_rdata;
                    alu_b   = b_rdata;
                    r_wdata = acc_nx;
                end
                OP_SMUL: begin
                    alu_a   = a_rdata;
                    alu_b   = sc_q;
                    r_wdata = alu_res;
                end
                OP_NEG: begin
                    alu_a   = a_rdata;
                    alu_b   = -8'sd1;
                    r_wdata = alu_res;
                end
                OP_TRN: begin
                    alu_a   = a_rdata;
                    alu_b   = 8'sd1;
                    r_wdata = alu_res;
                end
                default: r_wdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            alu_op <= '0;
            alu_s  <= '0;
            op_q   <= '0;
            n_q    <= '0;
            sc_q   <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        n_q    <= size;
                        sc_q   <= scalar;
                        acc    <= '0;
                        busy   <= 1'b1;
                        alu_op <= op;
                        alu_s  <= size;
                        if (bad_cmd(op, size, MAX_N)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Multiply writes only on the final inner-product term.
                    r_we   <= !is_mul || k_last;
                    r_addr <= (op_q == OP_TRN) ? lin(j, i) : lin(i, j);
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_we <= 1'b0;
                    if (is_mul)
                        acc <= r_we ? 8'sd0 : acc_nx;
                    if (last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    alu_op <= '0;
                    alu_s  <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_op_sequencer.sv
// Self-checking bench: table of commands, memory/ALU models and a write scoreboard.
module tb_mat_op_sequencer;
    import mat_pkg::*;

    localparam int MN = 5;

    logic              clk, rst, start;
    logic [2:0]        op, size;
    logic signed [7:0] scalar;
    logic              busy, done, err;
    logic [4:0]        a_addr, b_addr, r_addr;
    logic signed [7:0] a_rdata, b_rdata, r_wdata;
    logic              r_we;
    logic [2:0]        alu_op, alu_s;
    logic signed [7:0] alu_a, alu_b, alu_res;

    mat_op_sequencer #(.MAX_N(MN), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .size(size), .scalar(scalar),
        .busy(busy), .done(done), .err(err),
        .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .r_addr(r_addr), .r_wdata(r_wdata), .r_we(r_we),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_res(alu_res)
    );

    typedef struct {
        logic [2:0]        op;
        logic [2:0]        size;
        logic signed [7:0] sc;
        int                pat;
        int                cyc;
        logic              err;
        int                nw;
        logic              poke;
    } vec_t;

    typedef struct {
        logic [4:0]        addr;
        logic signed [7:0] data;
    } wr_t;

    logic signed [7:0] amem [32];
    logic signed [7:0] bmem [32];
    logic signed [7:0] rmem [32];
    wr_t  sbq[$];
    wr_t  e;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    vec_t tbl [14];

    function automatic logic signed [7:0] alu_f(logic [2:0] o, logic signed [7:0] a,
                                                logic signed [7:0] b);
        logic signed [15:0] p;
        p = a * b;
        case (o)
            OP_ADD:          return a + b;
            OP_SUB:          return a - b;
            OP_DET, OP_CLR:  return 8'sd0;
            default:         return p[7:0];
        endcase
    endfunction

    function automatic logic signed [7:0] acc_add(logic signed [7:0] a, logic signed [7:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef MAT_SEQ_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return 8'(s);
    endfunction

    assign alu_res = alu_f(alu_op, alu_a, alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        a_rdata <= amem[a_addr];
        b_rdata <= bmem[b_addr];
        if (r_we) rmem[r_addr] <= r_wdata;
    end

    always @(negedge clk) begin
        if (!rst && r_we) begin
            wr_cnt++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got write addr %0d data %0d, expected none", r_addr, r_wdata);
            end else begin
                e = sbq.pop_front();
                if (r_addr !== e.addr || r_wdata !== e.data) begin
                    errors++;
                    $display("FAIL sb_write: got addr %0d data %0d, expected addr %0d data %0d",
                             r_addr, r_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int x = 0; x < 32; x++) begin
            amem[x] = 8'($urandom);
            bmem[x] = 8'($urandom);
        end
        case (pat)
            0: for (int x = 0; x < 25; x++) begin amem[x] = 8'sd5; bmem[x] = -8'sd2; end
            1, 2: begin
                amem[0] = 8'sd1; amem[1] = 8'sd2; amem[5] = 8'sd3; amem[6] = 8'sd4;
                if (pat == 1) begin
                    bmem[0] = 8'sd4; bmem[1] = 8'sd3; bmem[5] = 8'sd2; bmem[6] = 8'sd1;
                end else begin
                    bmem[0] = 8'sd5; bmem[1] = 8'sd6; bmem[5] = 8'sd7; bmem[6] = 8'sd8;
                end
            end
            3: for (int x = 0; x < 25; x++) begin amem[x] = 8'sd100; bmem[x] = 8'sd1; end
            4: for (int x = 0; x < 25; x++) amem[x] = 8'(x);
            default: ;
        endcase
    endtask

    task automatic build_exp(input vec_t v);
        int n;
        logic signed [7:0] acc, a, b, d;
        n = int'(v.size);
        if (v.err) return;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                a = amem[i*MN+j];
                b = bmem[i*MN+j];
                case (v.op)
                    OP_MULT: begin
                        acc = 8'sd0;
                        for (int k = 0; k < n; k++)
                            acc = acc_add(acc, alu_f(OP_MULT, amem[i*MN+k], bmem[k*MN+j]));
                        sbq.push_back('{5'(i*MN+j), acc});
                    end
                    OP_TRN:  sbq.push_back('{5'(j*MN+i), a});
                    OP_CLR:  sbq.push_back('{5'(i*MN+j), 8'sd0});
                    OP_NEG: begin
                        d = -a;
                        sbq.push_back('{5'(i*MN+j), d});
                    end
                    OP_SMUL: sbq.push_back('{5'(i*MN+j), alu_f(OP_SMUL, a, v.sc)});
                    default: sbq.push_back('{5'(i*MN+j), alu_f(v.op, a, b)});
                endcase
            end
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int cnt;
        fill(v.pat);
        sbq.delete();
        build_exp(v);
        wr_cnt = 0;
        @(negedge clk);
        op = v.op; size = v.size; scalar = v.sc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 1;
        check("busy_after_start", int'(busy), 1);
        while (!done && cnt < 400) begin
            start = v.poke && (cnt == 3);
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        check("done_cycle", cnt, v.cyc);
        check("err_with_done", int'(err), int'(v.err));
        start = v.poke;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_pulse", int'(done), 0);
        check("busy_cleared", int'(busy), 0);
        check("err_held", int'(err), int'(v.err));
        check("write_count", wr_cnt, v.nw);
        check("sb_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        int bad_done;
        logic signed [7:0] sat_exp;
`ifdef MAT_SEQ_SAT_EN
        sat_exp = 8'sd127;
`else
        sat_exp = -8'sd56;
`endif
        tbl[0]  = '{OP_ADD,  3'd3, 8'sd0,  0, 19,  1'b0, 9,  1'b1};
        tbl[1]  = '{OP_SUB,  3'd2, 8'sd0,  1, 9,   1'b0, 4,  1'b0};
        tbl[2]  = '{OP_MULT, 3'd2, 8'sd0,  2, 17,  1'b0, 4,  1'b0};
        tbl[3]  = '{OP_MULT, 3'd2, 8'sd0,  3, 17,  1'b0, 4,  1'b0};
        tbl[4]  = '{OP_TRN,  3'd3, 8'sd0,  4, 19,  1'b0, 9,  1'b0};
        tbl[5]  = '{OP_DET,  3'd3, 8'sd0,  5, 1,   1'b1, 0,  1'b0};
        tbl[6]  = '{OP_ADD,  3'd6, 8'sd0,  5, 1,   1'b1, 0,  1'b0};
        tbl[7]  = '{OP_ADD,  3'd1, 8'sd0,  5, 1,   1'b1, 0,  1'b0};
        tbl[8]  = '{OP_SMUL, 3'd4, -8'sd3, 5, 33,  1'b0, 16, 1'b0};
        tbl[9]  = '{OP_NEG,  3'd5, 8'sd0,  5, 51,  1'b0, 25, 1'b0};
        tbl[10] = '{OP_CLR,  3'd3, 8'sd0,  5, 19,  1'b0, 9,  1'b0};
        tbl[11] = '{OP_MULT, 3'd3, 8'sd0,  5, 55,  1'b0, 9,  1'b0};
        tbl[12] = '{OP_MULT, 3'd5, 8'sd0,  5, 251, 1'b0, 25, 1'b0};
        tbl[13] = '{OP_SUB,  3'd5, 8'sd0,  5, 51,  1'b0, 25, 1'b1};

        rst = 1'b1; start = 1'b0; op = '0; size = '0; scalar = '0;
        fill(5);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done_err_we", int'({done, err, r_we}), 0);
        check("rst_addrs", int'({a_addr, b_addr, r_addr}), 0);
        check("rst_alu_drive", int'({alu_op, alu_s, alu_a, alu_b, r_wdata}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 14; t++) begin
            run_cmd(tbl[t]);
            if (t == 1) begin
                check("sub_r00", int'(rmem[0]), -3);
                check("sub_r01", int'(rmem[1]), -1);
                check("sub_r10", int'(rmem[5]), 1);
                check("sub_r11", int'(rmem[6]), 3);
            end
            if (t == 2) begin
                check("mul_r00", int'(rmem[0]), 19);
                check("mul_r01", int'(rmem[1]), 22);
                check("mul_r10", int'(rmem[5]), 43);
                check("mul_r11", int'(rmem[6]), 50);
            end
            if (t == 3) begin
                check("mul_ovf_r00", int'(rmem[0]), int'(sat_exp));
                check("mul_ovf_r11", int'(rmem[6]), int'(sat_exp));
            end
        end

        // Reset in the middle of a 5x5 multiply, then a normal command.
        fill(5);
        sbq.delete();
        build_exp(tbl[12]);
        @(negedge clk);
        op = OP_MULT; size = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_we", int'(r_we), 0);
        check("mid_rst_done", int'(done), 0);
        sbq.delete();
        rst = 1'b0;
        bad_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) bad_done++;
        end
        check("post_rst_quiet", bad_done, 0);
        run_cmd(tbl[2]);
        check("rerun_r00", int'(rmem[0]), 19);
        check("rerun_r11", int'(rmem[6]), 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_op_sequencer.md
# mat_op_sequencer

Sequencing controller for the matrix coprocessor's 8-bit signed element ALU. On a `start` command it walks the operand matrices held in two synchronous-read operand memories, presents one element pair per step to the ALU, accumulates dot products for matrix multiply, and writes each result element to the result memory. It sits between the coprocessor command register (HPS side) and the ALU/matrix memories, and is the only master of the ALU inputs.

## Interface
Parameters:
- `MAX_N`, 5: largest supported matrix dimension; memories are row-major, address = row*MAX_N + col.
- `AW`, 5: memory address width (≥ clog2(MAX_N*MAX_N)).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `op` in 3: opcode (000 add, 001 sub, 010 mult, 011 mult-by-scalar, 100 det, 101 transpose, 110 opposite, 111 clear); latched at start.
- `size` in 3: dimension N; latched at start; legal 2..MAX_N.
- `scalar` in 8 signed: multiplier for opcode 011; latched at start.
- `busy` out 1: high from the cycle after accepted start until done.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: valid with `done`; holds until next accepted start.
- `a_addr`, `b_addr` out AW: operand memory read addresses.
- `a_rdata`, `b_rdata` in 8 signed: read data, valid one cycle after address.
- `r_addr` out AW, `r_wdata` out 8 signed, `r_we` out 1: result memory write port.
- `alu_op` out 3, `alu_a`, `alu_b` out 8 signed, `alu_s` out 3: ALU drive.
- `alu_res` in 8 signed: combinational ALU result.

## Operation
- States: IDLE → FETCH → EXEC → (FETCH | DONE) → IDLE.
- IDLE: start=1 latches op/size/scalar, clears acc and err, resets i,j,k to 0, goes FETCH. If size<2 or >MAX_N, or op=100 (det unsupported), go directly DONE with err=1, no memory writes.
- FETCH: drive `a_addr`/`b_addr` for current step; next EXEC.
- EXEC: rdata valid; `alu_a`/`alu_b` driven per op:
  - 000/001: A[i][j], B[i][j]; write alu_res to (i,j).
  - 011: A[i][j], scalar; write (i,j).
  - 110: A[i][j], −1; write (i,j).
  - 101: A[i][j], +1; write to (j,i).
  - 010: A[i][k], B[k][j]; acc ← acc + alu_res; on k=N−1 write acc+alu_res to (i,j), clear acc.
  - 111: no ALU use; write 0 to (i,j).
- Index advance after EXEC: element-wise j fastest then i; multiply k fastest, then j, then i. After last step → DONE.
- DONE: done=1, busy=0 next cycle, return IDLE.
- `alu_op` = latched op, `alu_s` = latched size at all times outside IDLE.
- Accumulator 8-bit signed; add behaviour per Configuration.

## Timing
- Reset values: busy=0, done=0, err=0, r_we=0, all addresses 0, r_wdata=0, alu_a=alu_b=0, alu_op=0, alu_s=0; state IDLE, acc=0.
- Step = 2 cycles. Steps = N² (element-wise, clear) or N³ (multiply).
- start accepted at edge t → done high in cycle t+2·steps+1; error path: done in t+1.
- r_we high exactly in EXEC cycles that write; one write per result element.
- start while busy ignored; start and done same cycle: ignored (not IDLE).
- rst mid-operation: IDLE next edge, r_we=0 immediately, partial results left in memory, done not pulsed.

## Configuration
- `MAT_SEQ_SAT_EN` defined: multiply accumulation saturates to [−128,127] at each add (9-bit sum clamped).
- Undefined: accumulation wraps modulo 256, matching ALU add.

## Structure
- Shared package `mat_pkg`: opcode localparams (OP_ADD … OP_CLR), state enum, `MAX_N`.
- One sub-module natural: `mat_index_gen` — i/j/k counters with N-bounded wrap, mode select (2-D vs 3-D), `last` flag.

## Test plan
- Add 3×3, A=all 5, B=all −2 → nine writes of 3, done at cycle 19 after start.
- Sub 2×2 A=[1,2;3,4], B=[4,3,2,1] → R=[−3,−1,1,3], r_addr 0,1,5,6.
- Mult 2×2 A=[1,2;3,4], B=[5,6;7,8] → R=[19,22,43,50], 4 writes, done at cycle 17.
- Mult 2×2 A=all 100, B=all 1 → 200 wrap = −56 without `MAT_SEQ_SAT_EN`, 127 with it.
- Transpose 3×3 A[i][j]=i*5+j → R[j][i] equals A[i][j]; op=100 or size=6 → done at t+1, err=1, no r_we.
- rst asserted during 5×5 multiply → busy=0, r_we=0 next cycle, no done; new start then completes normally.
